cpu_branch_ctrl: RTL and testbench

- Program-counter and branch sequencer for the plotter CPU.
- Holds the compare-flags register (eq/gt/lt) and evaluates jump conditions on those flags plus live accelerator status.
- Updates the PC for sequential, jump, conditional-jump, call and return ops, and owns a bounded call stack.
- Sits between the instruction decoder (op/cond/target) and instruction memory (pc).

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_call_stack.sv | 45 ++++
 rtl/cpu_jmp_cond_decoder.sv | 31 +++
 rtl/cpu_branch_ctrl.sv | 129 ++++++++++++
 tb/tb_cpu_branch_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the plotter CPU: branch-unit op codes and jump condition codes.
package cpu_pkg;

  localparam int OP_WIDTH   = 3;
  localparam int COND_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_NEXT = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_JMP  = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_JMPC = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_CALL = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_RET  = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 3'd5;

  localparam logic [COND_WIDTH-1:0] COND_EQ  = 4'd0;
  localparam logic [COND_WIDTH-1:0] COND_NE  = 4'd1;
  localparam logic [COND_WIDTH-1:0] COND_LT  = 4'd2;
  localparam logic [COND_WIDTH-1:0] COND_LE  = 4'd3;
  localparam logic [COND_WIDTH-1:0] COND_GT  = 4'd4;
  localparam logic [COND_WIDTH-1:0] COND_GE  = 4'd5;
  localparam logic [COND_WIDTH-1:0] COND_CR  = 4'd6;
  localparam logic [COND_WIDTH-1:0] COND_CW  = 4'd7;
  localparam logic [COND_WIDTH-1:0] COND_NCR = 4'd8;
  localparam logic [COND_WIDTH-1:0] COND_NCW = 4'd9;

endpackage

// File: rtl/cpu_call_stack.sv
// Bounded LIFO of return addresses; the extra pointer bit keeps full and empty distinct.
module cpu_call_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_WIDTH    = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                full,
  output logic                empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]    sp;
  logic [IDX_W-1:0]    top_idx;
  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];

  assign full    = (sp == PTR_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = sp[IDX_W-1:0] - IDX_W'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PTR_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - PTR_W'(1);
    end
  end

  // Contents need no reset: an empty pointer makes them unreachable.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cpu_jmp_cond_decoder.sv
// Combinational jump-condition evaluation from compare flags and live accelerator status.
module cpu_jmp_cond_decoder
  import cpu_pkg::*;
(
  input  logic [COND_WIDTH-1:0] cond,
  input  logic                  eq,
  input  logic                  gt,
  input  logic                  lt,
  input  logic                  can_read,
  input  logic                  can_write,
  output logic                  hit
);

  always_comb begin
    hit = 1'b0;
    case (cond)
      COND_EQ:  hit = eq;
      COND_NE:  hit = !eq;
      COND_LT:  hit = lt;
      COND_LE:  hit = lt || eq;
      COND_GT:  hit = gt;
      COND_GE:  hit = gt || eq;
      COND_CR:  hit = can_read;
      COND_CW:  hit = can_write;
      COND_NCR: hit = !can_read;
      COND_NCW: hit = !can_write;
      default:  hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_branch_ctrl.sv
// Program counter and branch sequencer: compare flags, conditional jumps, call/return, halt.
module cpu_branch_ctrl #(
  parameter int PC_WIDTH    = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 8,
  parameter int COND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  cmp_valid,
  input  logic [DATA_WIDTH-1:0] cmp_a,
  input  logic [DATA_WIDTH-1:0] cmp_b,
  input  logic                  accel_can_read,
  input  logic                  accel_can_write,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [COND_WIDTH-1:0] cond,
  input  logic [PC_WIDTH-1:0]   target,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  taken,
  output logic                  halted,
  output logic                  stack_err
);

  import cpu_pkg::*;

  logic                flag_eq;
  logic                flag_gt;
  logic                flag_lt;
  logic                cond_hit;
  logic                accept;
  logic                push;
  logic                pop;
  logic                stk_full;
  logic                stk_empty;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                cmp_eq;
  logic                cmp_lt;

  assign accept = op_valid && !stall && !halted;
  assign pc_inc = pc + PC_WIDTH'(1);
  assign push   = accept && (op == OP_CALL) && !stk_full;
  assign pop    = accept && (op == OP_RET) && !stk_empty;
  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_lt = ($signed(cmp_a) < $signed(cmp_b));

  // Registered flags only, so a same-cycle compare never affects the JMPC beside it.
  cpu_jmp_cond_decoder u_cond (
    .cond      (cond),
    .eq        (flag_eq),
    .gt        (flag_gt),
    .lt        (flag_lt),
    .can_read  (accel_can_read),
    .can_write (accel_can_write),
    .hit       (cond_hit)
  );

  cpu_call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= '0;
      flag_eq   <= 1'b0;
      flag_gt   <= 1'b0;
      flag_lt   <= 1'b0;
      taken     <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (!stall && !halted && cmp_valid) begin
        flag_eq <= cmp_eq;
        flag_lt <= cmp_lt;
        flag_gt <= !cmp_eq && !cmp_lt;
      end
      if (accept) begin
        case (op)
          OP_JMP: begin
            pc    <= target;
            taken <= 1'b1;
          end
          OP_JMPC: begin
            if (cond_hit) begin
              pc    <= target;
              taken <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
          OP_CALL: begin
            if (!stk_full) begin
              pc    <= target;
              taken <= 1'b1;
            end else begin
              stack_err <= 1'b1;
              halted    <= 1'b1;
            end
          end
          OP_RET: begin
            if (!stk_empty) begin
              pc    <= stk_top;
              taken <= 1'b1;
            end else begin
              stack_err <= 1'b1;
              halted    <= 1'b1;
            end
          end
          OP_HALT: halted <= 1'b1;
          default: pc <= pc_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_branch_ctrl.sv
// Bench for cpu_branch_ctrl: directed scenarios with literal expectations, then random ops against a queue-based model.
module tb_cpu_branch_ctrl;

  localparam int PCW = 12;
  localparam int SD  = 8;
  localparam int PC_MOD = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        cmp_valid;
  logic [15:0] cmp_a;
  logic [15:0] cmp_b;
  logic        accel_can_read;
  logic        accel_can_write;
  logic        op_valid;
  logic [2:0]  op;
  logic [3:0]  cond;
  logic [11:0] target;
  logic [11:0] pc;
  logic        taken;
  logic        halted;
  logic        stack_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  int m_pc = 0;
  bit m_eq, m_gt, m_lt;
  bit m_halted, m_err, m_taken;
  int m_stack[$];

  cpu_branch_ctrl #(.PC_WIDTH(PCW), .DATA_WIDTH(16), .STACK_DEPTH(SD), .COND_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .cmp_valid(cmp_valid), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .accel_can_read(accel_can_read), .accel_can_write(accel_can_write), .op_valid(op_valid),
    .op(op), .cond(cond), .target(target), .pc(pc), .taken(taken), .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit cond_true(int c, bit eq, bit gt, bit lt, bit cr, bit cw);
    case (c)
      0: return eq;
      1: return !eq;
      2: return lt;
      3: return lt || eq;
      4: return gt;
      5: return gt || eq;
      6: return cr;
      7: return cw;
      8: return !cr;
      9: return !cw;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    int a, b;
    bit hit;
    if (!rst_n) begin
      m_pc = 0; m_eq = 0; m_gt = 0; m_lt = 0;
      m_stack.delete();
      m_halted = 0; m_err = 0; m_taken = 0;
      return;
    end
    m_taken = 0;
    if (stall || m_halted) return;
    hit = cond_true(int'(cond), m_eq, m_gt, m_lt, accel_can_read, accel_can_write);
    if (cmp_valid) begin
      a = $signed(cmp_a);
      b = $signed(cmp_b);
      m_eq = (a == b); m_lt = (a < b); m_gt = (a > b);
    end
    if (!op_valid) return;
    case (int'(op))
      1: begin m_pc = int'(target); m_taken = 1; end
      2: if (hit) begin m_pc = int'(target); m_taken = 1; end
         else m_pc = (m_pc + 1) % PC_MOD;
      3: if (m_stack.size() < SD) begin
           m_stack.push_back((m_pc + 1) % PC_MOD);
           m_pc = int'(target); m_taken = 1;
         end else begin m_err = 1; m_halted = 1; end
      4: if (m_stack.size() > 0) begin m_pc = m_stack.pop_back(); m_taken = 1; end
         else begin m_err = 1; m_halted = 1; end
      5: m_halted = 1;
      default: m_pc = (m_pc + 1) % PC_MOD;
    endcase
  endtask

  task automatic step(bit rn, bit st, bit cv, logic [15:0] a, logic [15:0] b,
                      bit ov, logic [2:0] o, logic [3:0] c, logic [11:0] t);
    rst_n = rn; stall = st; cmp_valid = cv; cmp_a = a; cmp_b = b;
    op_valid = ov; op = o; cond = c; target = t;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_op(logic [2:0] o, logic [3:0] c, logic [11:0] t);
    step(1, 0, 0, 16'd0, 16'd0, 1, o, c, t);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("taken", 32'(taken), 32'(m_taken));
      check("halted", 32'(halted), 32'(m_halted));
      check("stack_err", 32'(stack_err), 32'(m_err));
    end
  end

  initial begin
    accel_can_read = 1; accel_can_write = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    check("rst_pc", 32'(pc), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(stack_err), 0);

    for (int i = 1; i <= 3; i++) begin
      do_op(3'd0, 4'd0, 12'd0);
      check("next_pc", 32'(pc), 32'(i));
      check("next_taken", 32'(taken), 0);
    end
    do_op(3'd1, 4'd0, 12'd4095);
    check("jmp_taken", 32'(taken), 1);
    do_op(3'd0, 4'd0, 12'd0);
    check("wrap_pc", 32'(pc), 0);

    step(1, 0, 1, 16'hFFFD, 16'd5, 0, 3'd0, 4'd0, 12'd0);
    do_op(3'd2, 4'd2, 12'h040);
    check("jmpc_lt_pc", 32'(pc), 32'h40);
    check("jmpc_lt_taken", 32'(taken), 1);
    do_op(3'd2, 4'd5, 12'h050);
    check("jmpc_ge_pc", 32'(pc), 32'h41);
    check("jmpc_ge_taken", 32'(taken), 0);

    step(1, 0, 1, 16'd7, 16'd7, 1, 3'd2, 4'd0, 12'h080);
    check("old_flags_pc", 32'(pc), 32'h42);
    do_op(3'd2, 4'd0, 12'h080);
    check("new_flags_pc", 32'(pc), 32'h80);

    accel_can_read = 0;
    do_op(3'd2, 4'd8, 12'h010);
    check("ncr_pc", 32'(pc), 32'h10);
    accel_can_write = 1;
    do_op(3'd2, 4'd9, 12'h020);
    check("ncw_pc", 32'(pc), 32'h11);
    do_op(3'd2, 4'd12, 12'h030);
    check("cond12_pc", 32'(pc), 32'h12);
    accel_can_read = 1;

    do_op(3'd1, 4'd0, 12'd5);
    do_op(3'd3, 4'd0, 12'h100);
    check("call_pc", 32'(pc), 32'h100);
    do_op(3'd4, 4'd0, 12'd0);
    check("ret_pc", 32'(pc), 32'h6);
    for (int i = 0; i < 9; i++) do_op(3'd3, 4'd0, 12'(12'h200 + i));
    check("ovf_pc", 32'(pc), 32'h207);
    check("ovf_err", 32'(stack_err), 1);
    check("ovf_halted", 32'(halted), 1);
    do_op(3'd1, 4'd0, 12'h300);
    check("halted_jmp_pc", 32'(pc), 32'h207);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst2_pc", 32'(pc), 0);
    check("rst2_halted", 32'(halted), 0);
    check("rst2_err", 32'(stack_err), 0);
    do_op(3'd2, 4'd1, 12'h033);
    check("clr_ne_pc", 32'(pc), 32'h33);
    do_op(3'd2, 4'd3, 12'h044);
    check("clr_le_pc", 32'(pc), 32'h34);
    do_op(3'd4, 4'd0, 12'd0);
    check("unf_err", 32'(stack_err), 1);
    check("unf_halted", 32'(halted), 1);
    check("unf_pc", 32'(pc), 32'h34);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 3'd1, 4'd0, 12'h055);
    check("stall_pc", 32'(pc), 0);
    check("stall_taken", 32'(taken), 0);
    do_op(3'd1, 4'd0, 12'h055);
    check("unstall_pc", 32'(pc), 32'h55);

    for (int n = 0; n < 4000; n++) begin
      bit rn, st, cv, ov;
      logic [15:0] a, b;
      logic [2:0] o;
      int r;
      rn = ($urandom_range(0, 299) != 0);
      if (m_halted && ($urandom_range(0, 15) == 0)) rn = 0;
      st = ($urandom_range(0, 7) == 0);
      cv = ($urandom_range(0, 3) == 0);
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      ov = ($urandom_range(0, 5) != 0);
      r = $urandom_range(0, 15);
      if (r < 4) o = 3'd0;
      else if (r < 6) o = 3'd1;
      else if (r < 10) o = 3'd2;
      else if (r < 12) o = 3'd3;
      else if (r < 14) o = 3'd4;
      else if (r < 15) o = 3'd5;
      else o = 3'($urandom_range(6, 7));
      accel_can_read = 1'($urandom);
      accel_can_write = 1'($urandom);
      step(rn, st, cv, a, b, ov, o, 4'($urandom), 12'($urandom));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
